// File: rtl/obi_mux_tagged.sv
// ----------------------------------------------------------------------------
// obi_mux_tagged
//
// N:1 OBI multiplexer with per-port outstanding-transaction limits and two
// response-routing schemes:
//   UseIdTag = 1 : the selected port index is prepended to the A-channel ID.
//                  Responses are routed back by the upper R-channel ID bits,
//                  so they may return out of order.
//   UseIdTag = 0 : the granted port index is pushed into an index FIFO.
//                  Responses are routed strictly in order from the FIFO head.
// Arbitration is round-robin (FixedPrio = 0) or fixed priority with the
// lowest index winning (FixedPrio = 1). Once a request has been presented on
// the manager port, it stays locked in until it is granted. This keeps the
// OBI req and payload stable.
//
// Responses that match no outstanding transaction are orphans. An orphan is
// drained (mgr_rready_o = 1) and is never forwarded to any port.
//
// Optional feature macro: OBI_MUX_TAGGED_ORPHAN_FLAG_EN
//   When this macro is defined, the block adds a sticky orphan_o flag and an
//   orphan_port_o capture of the first orphan's destination index.
//
// Ports
//   clk_i, rst_ni            clock, synchronous active-low reset
//   sbr_req_i / sbr_gnt_o    per-port A-channel handshake
//   sbr_addr_i .. sbr_aid_i  per-port A-channel payload
//   sbr_rvalid_o/rready_i    per-port R-channel handshake
//   sbr_rdata_o/err_o/rid_o  R-channel payload, broadcast to all ports
//   mgr_*                    manager-side A and R channels
//   orphan_o, orphan_port_o  (macro only) sticky orphan flag and first index
// ----------------------------------------------------------------------------
module obi_mux_tagged #(
  parameter int unsigned NumSbrPorts     = 4,
  parameter int unsigned SbrIdWidth      = 2,
  parameter int unsigned IdxWidth        = $clog2(NumSbrPorts),
  parameter int unsigned MgrIdWidth      = SbrIdWidth + IdxWidth,
  parameter int unsigned AddrWidth       = 32,
  parameter int unsigned DataWidth       = 32,
  parameter bit          UseIdTag        = 1'b1,
  parameter int unsigned NumMaxTrans     = 4,
  parameter int unsigned MaxTransPerPort = 2,
  parameter bit          FixedPrio       = 1'b0
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [NumSbrPorts-1:0]                   sbr_req_i,
  output logic [NumSbrPorts-1:0]                   sbr_gnt_o,
  input  logic [NumSbrPorts-1:0][AddrWidth-1:0]    sbr_addr_i,
  input  logic [NumSbrPorts-1:0]                   sbr_we_i,
  input  logic [NumSbrPorts-1:0][DataWidth/8-1:0]  sbr_be_i,
  input  logic [NumSbrPorts-1:0][DataWidth-1:0]    sbr_wdata_i,
  input  logic [NumSbrPorts-1:0][SbrIdWidth-1:0]   sbr_aid_i,
  output logic [NumSbrPorts-1:0]                   sbr_rvalid_o,
  input  logic [NumSbrPorts-1:0]                   sbr_rready_i,
  output logic [DataWidth-1:0]                     sbr_rdata_o,
  output logic                                     sbr_err_o,
  output logic [SbrIdWidth-1:0]                    sbr_rid_o,
  output logic                                     mgr_req_o,
  input  logic                                     mgr_gnt_i,
  output logic [AddrWidth-1:0]                     mgr_addr_o,
  output logic                                     mgr_we_o,
  output logic [DataWidth/8-1:0]                   mgr_be_o,
  output logic [DataWidth-1:0]                     mgr_wdata_o,
  output logic [MgrIdWidth-1:0]                    mgr_aid_o,
  input  logic                                     mgr_rvalid_i,
  output logic                                     mgr_rready_o,
  input  logic [DataWidth-1:0]                     mgr_rdata_i,
  input  logic                                     mgr_err_i,
  input  logic [MgrIdWidth-1:0]                    mgr_rid_i
`ifdef OBI_MUX_TAGGED_ORPHAN_FLAG_EN
  ,
  output logic                                     orphan_o,
  output logic [IdxWidth-1:0]                      orphan_port_o
`endif
);

  localparam int unsigned CntWidth  = $clog2(MaxTransPerPort + 1);
  localparam int unsigned PtrWidth  = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
  localparam int unsigned FillWidth = $clog2(NumMaxTrans + 1);

  localparam logic [CntWidth-1:0]  CntMax  = CntWidth'(MaxTransPerPort);
  localparam logic [FillWidth-1:0] FillMax = FillWidth'(NumMaxTrans);
  localparam logic [IdxWidth-1:0]  IdxLast = IdxWidth'(NumSbrPorts - 1);
  localparam logic [PtrWidth-1:0]  PtrLast = PtrWidth'(NumMaxTrans - 1);

  // State
  logic [NumSbrPorts-1:0][CntWidth-1:0]  cnt_r;
  logic                                  lock_r;
  logic [IdxWidth-1:0]                   lock_idx_r;
  logic [IdxWidth-1:0]                   rr_ptr_r;
  logic [NumMaxTrans-1:0][IdxWidth-1:0]  fifo_mem_r;
  logic [PtrWidth-1:0]                   wr_ptr_r;
  logic [PtrWidth-1:0]                   rd_ptr_r;
  logic [FillWidth-1:0]                  fill_r;

  // Combinational nets
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [NumSbrPorts-1:0] eligible_s;
  logic                   arb_valid_s;
  logic [IdxWidth-1:0]    arb_idx_s;
  logic [IdxWidth-1:0]    sel_s;
  logic                   req_s;
  logic                   a_hs_s;
  logic [IdxWidth-1:0]    dest_s;
  logic                   dest_hit_s;
  logic                   dest_zero_s;
  logic                   orphan_s;
  logic                   rready_s;
  logic                   r_hs_s;
  logic                   push_s;
  logic                   pop_s;

  assign fifo_full_s  = (fill_r == FillMax);
  assign fifo_empty_s = (fill_r == {FillWidth{1'b0}});

  // Port eligibility: the port requests, is under its limit and, in FIFO mode, has room for its tag
  always_comb begin
    for (int i = 0; i < NumSbrPorts; i++) begin
      eligible_s[i] = sbr_req_i[i] && (cnt_r[i] < CntMax) && (UseIdTag || !fifo_full_s);
    end
  end

  // Arbiter: scan downwards so that the last hit is the highest-priority candidate
  always_comb begin
    int unsigned cand;
    arb_valid_s = 1'b0;
    arb_idx_s   = {IdxWidth{1'b0}};
    cand        = 0;
    if (FixedPrio) begin
      for (int i = NumSbrPorts - 1; i >= 0; i--) begin
        if (eligible_s[i]) begin
          arb_valid_s = 1'b1;
          arb_idx_s   = IdxWidth'(i);
        end else begin
          arb_valid_s = arb_valid_s;
        end
      end
    end else begin
      for (int k = NumSbrPorts - 1; k >= 0; k--) begin
        cand = (32'(rr_ptr_r) + 32'(k)) % NumSbrPorts;
        if (eligible_s[cand]) begin
          arb_valid_s = 1'b1;
          arb_idx_s   = IdxWidth'(cand);
        end else begin
          arb_valid_s = arb_valid_s;
        end
      end
    end
  end

  // The locked-in selection overrides the arbiter until the pending request is granted
  assign sel_s  = lock_r ? lock_idx_r : arb_idx_s;
  assign req_s  = rst_ni && (lock_r || arb_valid_s);
  assign a_hs_s = req_s && mgr_gnt_i;

  assign mgr_req_o   = req_s;
  assign mgr_addr_o  = sbr_addr_i[sel_s];
  assign mgr_we_o    = sbr_we_i[sel_s];
  assign mgr_be_o    = sbr_be_i[sel_s];
  assign mgr_wdata_o = sbr_wdata_i[sel_s];
  assign mgr_aid_o   = UseIdTag ? {sel_s, sbr_aid_i[sel_s]}
                                : {{IdxWidth{1'b0}}, sbr_aid_i[sel_s]};

  // Grant is returned only to the selected port
  always_comb begin
    for (int i = 0; i < NumSbrPorts; i++) begin
      sbr_gnt_o[i] = a_hs_s && (sel_s == IdxWidth'(i));
    end
  end

  // Response destination comes from the ID tag, or from the FIFO head in in-order mode
  assign dest_s = UseIdTag ? mgr_rid_i[MgrIdWidth-1:SbrIdWidth] : fifo_mem_r[rd_ptr_r];

  // Resolve the destination. It may not name a real port when N is not a power of two.
  always_comb begin
    dest_hit_s  = 1'b0;
    dest_zero_s = 1'b1;
    for (int i = 0; i < NumSbrPorts; i++) begin
      if (dest_s == IdxWidth'(i)) begin
        dest_hit_s  = 1'b1;
        dest_zero_s = (cnt_r[i] == {CntWidth{1'b0}});
      end else begin
        dest_hit_s  = dest_hit_s;
      end
    end
  end

  assign orphan_s = mgr_rvalid_i &&
                    (!dest_hit_s || dest_zero_s || (!UseIdTag && fifo_empty_s));

  // R-channel steering. An orphan is drained by forcing ready high.
  always_comb begin
    rready_s = 1'b1;
    for (int i = 0; i < NumSbrPorts; i++) begin
      sbr_rvalid_o[i] = rst_ni && mgr_rvalid_i && !orphan_s && (dest_s == IdxWidth'(i));
      if (!orphan_s && (dest_s == IdxWidth'(i))) begin
        rready_s = sbr_rready_i[i];
      end else begin
        rready_s = rready_s;
      end
    end
  end

  assign mgr_rready_o = rready_s;
  assign sbr_rdata_o  = mgr_rdata_i;
  assign sbr_err_o    = mgr_err_i;
  assign sbr_rid_o    = mgr_rid_i[SbrIdWidth-1:0];

  assign r_hs_s = mgr_rvalid_i && !orphan_s && rready_s;
  assign push_s = !UseIdTag && a_hs_s;
  assign pop_s  = !UseIdTag && r_hs_s;

  // Outstanding counters: count up on an A handshake and down on an R handshake. If both happen together, the count holds.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_r <= {NumSbrPorts{{CntWidth{1'b0}}}};
    end else begin
      for (int i = 0; i < NumSbrPorts; i++) begin
        if (a_hs_s && (sel_s == IdxWidth'(i)) && !(r_hs_s && (dest_s == IdxWidth'(i)))) begin
          cnt_r[i] <= cnt_r[i] + CntWidth'(1);
        end else if (r_hs_s && (dest_s == IdxWidth'(i)) && !(a_hs_s && (sel_s == IdxWidth'(i)))) begin
          cnt_r[i] <= cnt_r[i] - CntWidth'(1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  // Lock-in register: holds a presented but ungranted selection
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock_r     <= 1'b0;
      lock_idx_r <= {IdxWidth{1'b0}};
    end else if (req_s && !mgr_gnt_i) begin
      lock_r     <= 1'b1;
      lock_idx_r <= sel_s;
    end else if (a_hs_s) begin
      lock_r     <= 1'b0;
      lock_idx_r <= lock_idx_r;
    end else begin
      lock_r     <= lock_r;
      lock_idx_r <= lock_idx_r;
    end
  end

  // Round-robin pointer: after each handshake, it moves to the port just above the granted port
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_r <= {IdxWidth{1'b0}};
    end else if (a_hs_s) begin
      rr_ptr_r <= (sel_s == IdxLast) ? {IdxWidth{1'b0}} : sel_s + IdxWidth'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Index FIFO for in-order routing. A push and a pop may happen in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fifo_mem_r <= {NumMaxTrans{{IdxWidth{1'b0}}}};
      wr_ptr_r   <= {PtrWidth{1'b0}};
      rd_ptr_r   <= {PtrWidth{1'b0}};
      fill_r     <= {FillWidth{1'b0}};
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= sel_s;
        wr_ptr_r <= (wr_ptr_r == PtrLast) ? {PtrWidth{1'b0}} : wr_ptr_r + PtrWidth'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PtrLast) ? {PtrWidth{1'b0}} : rd_ptr_r + PtrWidth'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      if (push_s && !pop_s) begin
        fill_r <= fill_r + FillWidth'(1);
      end else if (pop_s && !push_s) begin
        fill_r <= fill_r - FillWidth'(1);
      end else begin
        fill_r <= fill_r;
      end
    end
  end

`ifdef OBI_MUX_TAGGED_ORPHAN_FLAG_EN
  logic                orphan_r;
  logic [IdxWidth-1:0] orphan_port_r;

  // Sticky orphan flag. The port index is captured only for the first orphan.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      orphan_r      <= 1'b0;
      orphan_port_r <= {IdxWidth{1'b0}};
    end else if (orphan_s && rready_s && !orphan_r) begin
      orphan_r      <= 1'b1;
      orphan_port_r <= dest_s;
    end else begin
      orphan_r      <= orphan_r;
      orphan_port_r <= orphan_port_r;
    end
  end

  assign orphan_o      = orphan_r;
  assign orphan_port_o = orphan_port_r;
`endif

endmodule
